uart_rx_fsm: RTL and testbench

- UART receiver: the counterpart to the team's UART transmitter. Fixed 8N1 frame format.
- Recovers bytes from the asynchronous serial line `uart_rx` using an internal baud counter and mid-bit sampling.
- Presents each good byte on a parallel bus with a one-cycle valid pulse. Flags framing errors.
- Sits between the board RX pin and the command/loopback logic that feeds the transmitter.

---
 rtl/uart_rx_fsm.sv | 132 +++++++++++++
 tb/tb_uart_rx_fsm.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// 8N1 UART receiver: synchronizes uart_rx, finds the start edge, samples each bit
// at its midpoint and reports a good byte (valid pulse) or a bad stop bit (frame_err pulse).
module uart_rx_fsm #(
   parameter int CLK_FREQ = 12000000,
   parameter int BAUD     = 9600,
   parameter int BPS_CNT  = CLK_FREQ / BAUD,
   parameter int HALF_CNT = BPS_CNT / 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic [7:0] rx_data,
   output logic       rx_data_valid,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int CNT_W = $clog2(BPS_CNT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BPS_CNT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       bit_idx, bit_idx_nxt;
   logic [7:0]       shift, shift_nxt;
   logic [7:0]       rx_data_nxt;
   logic             valid_nxt, err_nxt;
   logic             rx_meta, rx_s, rx_d;
   logic             fall;

   // Two-flop synchronizer plus one delay flop for edge detection; all idle high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_d    <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_s    <= rx_meta;
         rx_d    <= rx_s;
      end
   end

   assign fall    = rx_d & ~rx_s;
   assign rx_busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         shift         <= '0;
         rx_data       <= '0;
         rx_data_valid <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         bit_idx       <= bit_idx_nxt;
         shift         <= shift_nxt;
         rx_data       <= rx_data_nxt;
         rx_data_valid <= valid_nxt;
         frame_err     <= err_nxt;
      end
   end

   // Start is confirmed half a bit after the edge; later samples are one full bit apart
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift;
      rx_data_nxt = rx_data;
      valid_nxt   = 1'b0;
      err_nxt     = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (fall) begin
               state_nxt = START;
            end
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_nxt = '0;
               if (!rx_s) begin
                  state_nxt   = DATA;
                  bit_idx_nxt = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt            = '0;
               shift_nxt[bit_idx] = rx_s;
               bit_idx_nxt        = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_nxt = STOP;
               end
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
               if (rx_s) begin
                  rx_data_nxt = shift;
                  valid_nxt   = 1'b1;
               end else begin
                  err_nxt = 1'b1;
               end
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: table of frames, hand-written corner sequences,
// and random frames compared against an event-level model of the expected receiver output.
module tb_uart_rx_fsm;

   localparam int CLK_FREQ = 12000000;
   localparam int BAUD     = 120000;
   localparam int BPS      = CLK_FREQ / BAUD;
   localparam int HALF     = BPS / 2;
   localparam int LATENCY  = HALF + 9 * BPS + 3;
   localparam int GLITCH   = 16;

   logic       clk;
   logic       rst_n;
   logic       uart_rx;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       frame_err;
   logic       rx_busy;

   uart_rx_fsm #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .uart_rx      (uart_rx),
      .rx_data      (rx_data),
      .rx_data_valid(rx_data_valid),
      .frame_err    (frame_err),
      .rx_busy      (rx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         period;
      int         exp_valid;
      int         exp_ferr;
      logic [7:0] exp_data;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int cycle = 0;
   int fall_cycle = 0;
   int last_valid_cycle = 0;
   int valid_cnt = 0;
   int ferr_cnt = 0;
   int both_cnt = 0;
   int unstable_cnt = 0;
   int cur_run = 0;
   int max_run = 0;
   bit busy_window = 1'b0;
   logic [7:0] last_data = 8'h00;
   logic [7:0] model_data = 8'h00;
   logic [8:0] exp_q[$];
   logic [8:0] act_q[$];

   always @(posedge clk) cycle <= cycle + 1;

   // Observes the DUT on the falling edge and turns pulses into an event stream
   always @(negedge clk) begin
      if (!rst_n) begin
         last_data = 8'h00;
      end else begin
         if (rx_data_valid && frame_err) both_cnt++;
         if (rx_data_valid) begin
            valid_cnt++;
            act_q.push_back({1'b0, rx_data});
            last_data = rx_data;
            last_valid_cycle = cycle;
         end else if (rx_data != last_data) begin
            unstable_cnt++;
         end
         if (frame_err) begin
            ferr_cnt++;
            act_q.push_back({1'b1, 8'h00});
         end
         if (busy_window) begin
            if (!rx_busy) begin
               cur_run++;
               if (cur_run > max_run) max_run = cur_run;
            end else begin
               cur_run = 0;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual,
                  expected, expected);
      end
   endtask

   task automatic checkRange(input string name, input int actual, input int lo, input int hi);
      checks++;
      if (actual < lo || actual > hi) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
      end
   endtask

   task automatic holdLine(input logic v, input int n);
      uart_rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Transmits one 8N1 frame and records what a correct receiver must report for it
   task automatic applyStimulus(input logic [7:0] d, input logic stop, input int period);
      fall_cycle = cycle;
      holdLine(1'b0, period);
      for (int i = 0; i < 8; i++) holdLine(d[i], period);
      holdLine(stop, period);
      if (stop) begin
         exp_q.push_back({1'b0, d});
         model_data = d;
      end else begin
         exp_q.push_back({1'b1, 8'h00});
      end
   endtask

   task automatic checkQueues(input string name);
      int n;
      checkOutput({name, "_events"}, act_q.size(), exp_q.size());
      n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         checkOutput($sformatf("%s_event%0d", name, i), int'(act_q[i]), int'(exp_q[i]));
      act_q.delete();
      exp_q.delete();
   endtask

   vec_t vecs[7];

   initial begin
      int vb, fb, g0, gap;
      logic [7:0] rb;
      logic rs;

      vecs[0] = '{8'hA5, 1'b1, BPS,      1, 0, 8'hA5};
      vecs[1] = '{8'h96, 1'b1, BPS - 3,  1, 0, 8'h96};
      vecs[2] = '{8'h96, 1'b1, BPS + 3,  1, 0, 8'h96};
      vecs[3] = '{8'h81, 1'b0, BPS,      0, 1, 8'h96};
      vecs[4] = '{8'h7E, 1'b1, BPS,      1, 0, 8'h7E};
      vecs[5] = '{8'h00, 1'b1, BPS,      1, 0, 8'h00};
      vecs[6] = '{8'hFF, 1'b1, BPS,      1, 0, 8'hFF};

      rst_n = 1'b0;
      uart_rx = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_rx_data", rx_data, 8'h00);
      checkOutput("reset_valid", rx_data_valid, 0);
      checkOutput("reset_frame_err", frame_err, 0);
      checkOutput("reset_busy", rx_busy, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      holdLine(1'b1, 20);

      for (int i = 0; i < 7; i++) begin
         vb = valid_cnt;
         fb = ferr_cnt;
         applyStimulus(vecs[i].data, vecs[i].stop, vecs[i].period);
         if (!vecs[i].stop) holdLine(1'b0, 2 * BPS);
         holdLine(1'b1, 20);
         checkOutput($sformatf("vec%0d_valid", i), valid_cnt - vb, vecs[i].exp_valid);
         checkOutput($sformatf("vec%0d_ferr", i), ferr_cnt - fb, vecs[i].exp_ferr);
         checkOutput($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_data);
         if (vecs[i].stop && vecs[i].period == BPS)
            checkRange($sformatf("vec%0d_latency", i), last_valid_cycle - fall_cycle,
                       LATENCY - 1, LATENCY + 1);
      end
      checkQueues("table");

      // Back-to-back frames with no idle between stop and next start
      max_run = 0;
      cur_run = 0;
      busy_window = 1'b1;
      applyStimulus(8'h00, 1'b1, BPS);
      applyStimulus(8'hFF, 1'b1, BPS);
      applyStimulus(8'h55, 1'b1, BPS);
      busy_window = 1'b0;
      holdLine(1'b1, 20);
      checkQueues("b2b");
      checkOutput("b2b_data", rx_data, 8'h55);
      checkRange("b2b_busy_gap", max_run, 1, BPS - 1);

      // Start glitch shorter than half a bit
      vb = valid_cnt;
      fb = ferr_cnt;
      g0 = cycle;
      holdLine(1'b0, GLITCH);
      @(negedge clk);
      checkOutput("glitch_busy_high", rx_busy, 1);
      @(posedge clk);
      #1;
      uart_rx = 1'b1;
      while (cycle < g0 + HALF + 3) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      checkOutput("glitch_busy_low", rx_busy, 0);
      holdLine(1'b1, 20);
      checkOutput("glitch_valid", valid_cnt - vb, 0);
      checkOutput("glitch_ferr", ferr_cnt - fb, 0);
      applyStimulus(8'h3C, 1'b1, BPS);
      holdLine(1'b1, 20);
      checkQueues("glitch");
      checkOutput("glitch_next_data", rx_data, 8'h3C);

      // Reset asserted during data bit 4 of 0xC3; the transmitter abandons the frame
      vb = valid_cnt;
      fb = ferr_cnt;
      holdLine(1'b0, BPS);
      for (int i = 0; i < 4; i++) holdLine(((8'hC3 >> i) & 8'h01) != 0, BPS);
      holdLine(1'b0, BPS / 2);
      rst_n = 1'b0;
      uart_rx = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      checkOutput("midreset_rx_data", rx_data, 8'h00);
      checkOutput("midreset_busy", rx_busy, 0);
      checkOutput("midreset_valid", rx_data_valid, 0);
      checkOutput("midreset_ferr", frame_err, 0);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_data = 8'h00;
      holdLine(1'b1, 2 * BPS);
      checkOutput("midreset_no_valid", valid_cnt - vb, 0);
      checkOutput("midreset_no_ferr", ferr_cnt - fb, 0);
      checkOutput("midreset_data_held", rx_data, 8'h00);
      applyStimulus(8'h12, 1'b1, BPS);
      holdLine(1'b1, 20);
      checkQueues("midreset");
      checkOutput("midreset_next_data", rx_data, 8'h12);

      // Random frames with slight baud error, occasional bad stop bits and random gaps
      for (int i = 0; i < 8; i++) begin
         rb = 8'($urandom_range(0, 255));
         rs = ($urandom_range(0, 7) != 0);
         applyStimulus(rb, rs, $urandom_range(BPS - 2, BPS + 2));
         gap = rs ? $urandom_range(0, 30) : $urandom_range(4, 30);
         if (gap > 0) holdLine(1'b1, gap);
      end
      holdLine(1'b1, 2 * BPS);
      checkQueues("random");
      checkOutput("random_data", rx_data, model_data);

      checkOutput("valid_and_ferr_overlap", both_cnt, 0);
      checkOutput("rx_data_unstable", unstable_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
